// File: rtl/search_pkg.sv
// search_pkg -- shared definitions for the binary search controller.
//   state_t      : FSM state encoding (IDLE, SEARCH, DONE, ERR)
//   iter_width() : width of the compare counter for a given data width
//   ITER_W       : counter width for the default 32-bit data path
package search_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    localparam int unsigned DATAWIDTH_DEFAULT = 32;

    // The counter must hold DATAWIDTH+1, the worst-case number of compares.
    function automatic int unsigned iter_width(input int unsigned dw);
        return $clog2(dw + 2);
    endfunction

    localparam int unsigned ITER_W = iter_width(DATAWIDTH_DEFAULT);

endpackage

// File: rtl/search_bounds.sv
// search_bounds -- low/high bound registers and midpoint probe generation.
//   Clk, Rst  : clock, asynchronous active-high reset (clears both bounds)
//   init      : load the full range low=0, high=all-ones
//   active    : probe is driven only while active, otherwise 0
//   dec_high  : high <= probe-1 (key is below the probe)
//   inc_low   : low  <= probe+1 (key is above the probe)
//   probe     : low + ((high-low)>>1) when active
//   at_low    : midpoint equals low  (no room left below)
//   at_high   : midpoint equals high (no room left above)
module search_bounds #(
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 init,
    input  logic                 active,
    input  logic                 dec_high,
    input  logic                 inc_low,
    output logic [DATAWIDTH-1:0] probe,
    output logic                 at_low,
    output logic                 at_high
);

    localparam logic [DATAWIDTH-1:0] ONE = DATAWIDTH'(1);

    logic [DATAWIDTH-1:0] low;
    logic [DATAWIDTH-1:0] high;
    logic [DATAWIDTH-1:0] mid;

    // high >= low holds throughout a search, so the difference form never
    // overflows the way (low+high)>>1 would.
    always_comb begin
        mid     = low + ((high - low) >> 1);
        probe   = active ? mid : '0;
        at_low  = (mid == low);
        at_high = (mid == high);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            low  <= '0;
            high <= '0;
        end else if (init) begin
            low  <= '0;
            high <= '1;
        end else begin
            if (dec_high) high <= mid - ONE;
            if (inc_low)  low  <= mid + ONE;
        end
    end

endmodule

// File: rtl/binary_search_ctrl.sv
// binary_search_ctrl -- drives an external comparator to locate a key by
// successive halving of the range 0..2^DATAWIDTH-1, one compare per cycle.
//   Clk, Rst   : clock, asynchronous active-high reset
//   start      : request a search (sampled in IDLE, DONE and ERR)
//   probe      : value presented to the comparator a-input (0 outside SEARCH)
//   gt, lt, eq : comparator flags for probe vs key
//   busy       : high while searching
//   done       : one-cycle pulse when the key is found
//   result     : matched key, held until the next accepted start
//   iters      : compares used for the match, held with result
//   err        : inconsistent comparator flags, exhausted range or
//                compare limit reached; held until start or reset
module binary_search_ctrl
    import search_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DATAWIDTH_DEFAULT
) (
    input  logic                             Clk,
    input  logic                             Rst,
    input  logic                             start,
    output logic [DATAWIDTH-1:0]             probe,
    input  logic                             gt,
    input  logic                             lt,
    input  logic                             eq,
    output logic                             busy,
    output logic                             done,
    output logic [DATAWIDTH-1:0]             result,
    output logic [iter_width(DATAWIDTH)-1:0] iters,
    output logic                             err
);

    localparam int unsigned    IW       = iter_width(DATAWIDTH);
    localparam logic [IW-1:0]  ITER_MAX = IW'(DATAWIDTH + 1);

    state_t        state;
    logic [IW-1:0] count;
    logic [IW-1:0] count_nxt;
    logic          in_search;
    logic          one_hot;
    logic          at_low;
    logic          at_high;
    logic          bnd_init;
    logic          bnd_dec;
    logic          bnd_inc;
    logic          step_err;

    always_comb begin
        in_search = (state == ST_SEARCH);
        one_hot   = $onehot({gt, lt, eq});
        bnd_init  = !in_search && start;
        bnd_dec   = in_search && one_hot && gt && !at_low;
        bnd_inc   = in_search && one_hot && lt && !at_high;
        count_nxt = count + IW'(1);
        // Only evaluated when the compare is not a clean match.
        step_err  = !one_hot || (gt && at_low) || (lt && at_high) ||
                    (count_nxt == ITER_MAX);
    end

    search_bounds #(
        .DATAWIDTH (DATAWIDTH)
    ) u_bounds (
        .Clk      (Clk),
        .Rst      (Rst),
        .init     (bnd_init),
        .active   (in_search),
        .dec_high (bnd_dec),
        .inc_low  (bnd_inc),
        .probe    (probe),
        .at_low   (at_low),
        .at_high  (at_high)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= ST_IDLE;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            iters  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state  <= ST_SEARCH;
                        count  <= '0;
                        busy   <= 1'b1;
                        err    <= 1'b0;
                        result <= '0;
                        iters  <= '0;
                    end else if (state == ST_DONE) begin
                        state <= ST_IDLE;
                    end
                end
                ST_SEARCH: begin
                    count <= count_nxt;
                    if (one_hot && eq) begin
                        state  <= ST_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= probe;
                        iters  <= count_nxt;
                    end else if (step_err) begin
                        state <= ST_ERR;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/binary_search_ctrl.md
BINARY_SEARCH_CTRL -- requirements
Module: binary_search_ctrl

Interface
REQ-001 Parameter DATAWIDTH, default 32, SHALL set the width of the probe, the result and the search range 0..2^DATAWIDTH-1.
REQ-002 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 start  input  1  SHALL be the search request; sampled only in IDLE, DONE and ERR.
REQ-005 probe  output  DATAWIDTH  SHALL be the value driven to the a-input of an external Comparator whose b-input holds the key.
REQ-006 gt, lt, eq  input  1 each  SHALL be the Comparator flags for probe vs key (gt: probe>key; lt: probe<key; eq: equal).
REQ-007 busy  output  1  SHALL be high in SEARCH only.
REQ-008 done  output  1  SHALL be a one-cycle pulse on entry to DONE.
REQ-009 result  output  DATAWIDTH  SHALL be the matched key, held until the next accepted start.
REQ-010 iters  output  clog2(DATAWIDTH+2)  SHALL be the number of compares used, held with result.
REQ-011 err  output  1  SHALL be high in ERR.

Function
REQ-012 States SHALL be IDLE, SEARCH, DONE and ERR.
REQ-013 IDLE/DONE/ERR with start=1 -> SEARCH next cycle; low=0, high=all-ones, iteration counter=0, err/result/iters cleared.
REQ-014 probe SHALL be combinational: low + ((high - low) >> 1), computed at DATAWIDTH bits with no overflow.
REQ-015 probe SHALL be 0 outside SEARCH.
REQ-016 In SEARCH, each cycle SHALL consume exactly one compare and increment the iteration counter.
REQ-017 Flags {gt,lt,eq} with eq only -> DONE; result=probe; iters=counter+1.
REQ-018 Flags with gt only -> high=probe-1.
REQ-019 Flags with lt only -> low=probe+1.
REQ-020 Flags not exactly one-hot -> ERR.
REQ-021 gt with probe==low, or lt with probe==high (range exhausted, no wrap-around), -> ERR.
REQ-022 Iteration counter reaching DATAWIDTH+1 without eq -> ERR.
REQ-023 start during SEARCH SHALL be ignored.
REQ-024 DONE without start -> IDLE next cycle; result and iters stay held.
REQ-025 ERR SHALL hold until start or reset.
REQ-026 Worst-case latency SHALL be DATAWIDTH+1 compares from SEARCH entry to done.

Reset
REQ-027 Rst=1 SHALL immediately force IDLE with probe=0, busy=0, done=0, result=0, iters=0, err=0, and clear low, high and the counter.
REQ-028 Rst asserted mid-search SHALL abandon the search; no done pulse follows.
REQ-029 After Rst deasserts, the block SHALL wait in IDLE for start.

Structure
REQ-030 State encodings and the ITER_W width constant SHALL live in the shared package search_pkg.
REQ-031 The low/high bound registers and midpoint logic SHALL form one sub-module, search_bounds; the FSM and counter stay in binary_search_ctrl.
REQ-032 The Comparator SHALL remain external; the bench instantiates the existing Comparator as the responder.

Verification
REQ-033 DATAWIDTH=8, key=127, start -> first probe=127, eq; done pulse after 1 compare; result=127; iters=1.
REQ-034 DATAWIDTH=8, key=0 -> probes 127,63,31,15,7,3,1,0; result=0; iters=8.
REQ-035 DATAWIDTH=8, key=255 -> probes 127,191,223,239,247,251,253,254,255; result=255; iters=9; no wrap.
REQ-036 Bench forces gt=lt=1 on the 3rd compare -> ERR next cycle, err=1, busy=0; then start with a correct Comparator clears err and the search completes.
REQ-037 Rst pulsed on the 4th compare of key=200 -> all outputs 0 immediately, no done pulse; a fresh start yields result=200.
REQ-038 start held high through a search for key=90 -> no restart during SEARCH; exactly one done pulse; then a new search begins from DONE.
